// File: rtl/multi_channel_enable_gen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator:
// channel FSM states and the meaning of the per-channel mode bit.
package multi_channel_enable_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chanState_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/multi_channel_enable_gen_channel.sv
// One programmable enable generator: counts up to a latched terminal count,
// pulses hit for one cycle at the terminal count, then wraps (periodic) or
// goes idle (one-shot). A toggle register flips on every hit cycle.
module multi_channel_enable_gen_channel
    import multi_channel_enable_gen_pkg::*;
#(
    parameter int unsigned      WIDTH      = 26,
    parameter logic [WIDTH-1:0] DEFAULT_TC = WIDTH'(50_000_000),
    parameter bit               AUTO_START = 1'b1
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [WIDTH-1:0] tc,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic             hit,
    output logic             toggle,
    output logic             busy
);

    chanState_t       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_tcQ;
    logic             r_modeQ;
    logic             r_toggle;
    logic             w_hit;

    // hit and busy come only from registered state, so no input reaches an output combinationally
    assign w_hit  = (r_state == ST_RUN) && (r_count == r_tcQ);
    assign hit    = w_hit;
    assign busy   = (r_state == ST_RUN);
    assign toggle = r_toggle;

    // Channel FSM: stop beats start beats clear; the hit cycle either reloads the period or ends a one-shot
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_tcQ    <= DEFAULT_TC;
            r_modeQ  <= MODE_PERIODIC;
            r_toggle <= 1'b0;
            if (AUTO_START) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            if (w_hit) begin
                r_toggle <= ~r_toggle;
            end
            if (stop) begin
                r_state <= ST_IDLE;
                r_count <= '0;
            end else if (start) begin
                r_tcQ   <= tc;
                r_modeQ <= mode;
                r_count <= '0;
                r_state <= ST_RUN;
            end else if (r_state == ST_RUN) begin
                if (w_hit) begin
                    r_count <= '0;
                    if (r_modeQ == MODE_ONESHOT) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tcQ <= tc;
                    end
                end else if (clear) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_channel_enable_gen.sv
// N_CH fully independent enable generators sharing one clock and reset.
// The terminal-count bus is packed: channel i uses tc[i*WIDTH +: WIDTH].
module multi_channel_enable_gen
    import multi_channel_enable_gen_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned DEFAULT_TC = 50_000_000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                  ck,
    input  logic                  reset,
    input  logic [N_CH*WIDTH-1:0] tc,
    input  logic [N_CH-1:0]       mode,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       clear,
    output logic [N_CH-1:0]       hit,
    output logic [N_CH-1:0]       toggle,
    output logic [N_CH-1:0]       busy
);

    for (genvar i = 0; i < N_CH; i++) begin : gChannel
        multi_channel_enable_gen_channel #(
            .WIDTH      (WIDTH),
            .DEFAULT_TC (WIDTH'(DEFAULT_TC)),
            .AUTO_START (AUTO_START)
        ) uChannel (
            .ck     (ck),
            .reset  (reset),
            .tc     (tc[i*WIDTH +: WIDTH]),
            .mode   (mode[i]),
            .start  (start[i]),
            .stop   (stop[i]),
            .clear  (clear[i]),
            .hit    (hit[i]),
            .toggle (toggle[i]),
            .busy   (busy[i])
        );
    end

endmodule
